// File: rtl/mm_host_master.sv
// Memory-mapped bus initiator: serves host read/write commands and periodically
// polls the status words at 0x01/0x02, publishing decoded status and error-burst alarms.
module mm_host_master #(
  parameter int unsigned POLL_PERIOD = 1000,
  parameter int unsigned ERR_THRESH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        mm_write_en,
  output logic        mm_read_en,
  output logic [7:0]  mm_addr,
  output logic [31:0] mm_wdata,
  input  logic [31:0] mm_rdata,
  input  logic        poll_enable,
  output logic        status_valid,
  output logic [1:0]  status_active_channel,
  output logic [3:0]  status_signal_present,
  output logic [31:0] status_err_count,
  output logic [3:0]  err_alarm,
  input  logic        alarm_clear
);

  typedef enum logic [3:0] {
    IDLE, WR, RD_ISSUE, RD_WAIT, RD_DONE,
    P1_ISSUE, P1_WAIT, P2_ISSUE, P2_WAIT, P_DONE
  } state_t;

  localparam logic [19:0] TIMER_LAST = 20'(POLL_PERIOD - 1);
  localparam logic [7:0]  THRESH     = 8'(ERR_THRESH);

  state_t      state_q, state_d;
  logic        mm_write_en_q, mm_write_en_d;
  logic        mm_read_en_q, mm_read_en_d;
  logic [7:0]  mm_addr_q, mm_addr_d;
  logic [31:0] mm_wdata_q, mm_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        status_valid_q, status_valid_d;
  logic [1:0]  status_active_channel_q, status_active_channel_d;
  logic [3:0]  status_signal_present_q, status_signal_present_d;
  logic [31:0] status_err_count_q, status_err_count_d;
  logic [3:0]  err_alarm_q, err_alarm_d;
  logic [5:0]  p1_word_q, p1_word_d;
  logic [31:0] prev_cnt_q, prev_cnt_d;
  logic        prev_valid_q, prev_valid_d;
  logic [19:0] timer_q, timer_d;
  logic        poll_pending_q, poll_pending_d;
  logic        poll_set, poll_clr;
  logic [3:0]  alarm_set;

  // Per-channel 8-bit counter increase (modulo 256) compared against the threshold.
  function automatic logic [3:0] burst_alarms(input logic [31:0] new_cnt,
                                              input logic [31:0] old_cnt);
    logic [7:0] delta;
    logic [3:0] hit;
    hit = '0;
    for (int i = 0; i < 4; i++) begin
      delta  = new_cnt[8*i +: 8] - old_cnt[8*i +: 8];
      hit[i] = (delta >= THRESH);
    end
    return hit;
  endfunction

  assign cmd_ready = (state_q == IDLE) && !poll_pending_q && !rst;

  always_comb begin
    state_d                 = state_q;
    mm_write_en_d           = 1'b0;
    mm_read_en_d            = 1'b0;
    mm_addr_d               = mm_addr_q;
    mm_wdata_d              = mm_wdata_q;
    rsp_valid_d             = 1'b0;
    rsp_rdata_d             = rsp_rdata_q;
    status_valid_d          = 1'b0;
    status_active_channel_d = status_active_channel_q;
    status_signal_present_d = status_signal_present_q;
    status_err_count_d      = status_err_count_q;
    p1_word_d               = p1_word_q;
    prev_cnt_d              = prev_cnt_q;
    prev_valid_d            = prev_valid_q;
    poll_set                = 1'b0;
    poll_clr                = 1'b0;
    alarm_set               = '0;

    if (!poll_enable) begin
      timer_d = '0;
    end else if (timer_q == TIMER_LAST) begin
      timer_d  = '0;
      poll_set = 1'b1;
    end else begin
      timer_d = timer_q + 20'd1;
    end

    case (state_q)
      IDLE: begin
        if (poll_pending_q) begin
          state_d      = P1_ISSUE;
          mm_read_en_d = 1'b1;
          mm_addr_d    = 8'h01;
        end else if (cmd_valid && cmd_ready) begin
          mm_addr_d = cmd_addr;
          if (cmd_write) begin
            state_d       = WR;
            mm_write_en_d = 1'b1;
            mm_wdata_d    = cmd_wdata;
          end else begin
            state_d      = RD_ISSUE;
            mm_read_en_d = 1'b1;
          end
        end
      end
      WR: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        state_d     = RD_DONE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = mm_rdata;
      end
      RD_DONE:  state_d = IDLE;
      P1_ISSUE: state_d = P1_WAIT;
      P1_WAIT: begin
        state_d      = P2_ISSUE;
        p1_word_d    = mm_rdata[5:0];
        mm_read_en_d = 1'b1;
        mm_addr_d    = 8'h02;
      end
      P2_ISSUE: state_d = P2_WAIT;
      P2_WAIT: begin
        // Status outputs are loaded here so they are visible with status_valid in P_DONE.
        state_d                 = P_DONE;
        status_valid_d          = 1'b1;
        status_active_channel_d = p1_word_q[1:0];
        status_signal_present_d = p1_word_q[5:2];
        status_err_count_d      = mm_rdata;
        if (prev_valid_q) alarm_set = burst_alarms(mm_rdata, prev_cnt_q);
        prev_cnt_d   = mm_rdata;
        prev_valid_d = 1'b1;
      end
      P_DONE: begin
        state_d  = IDLE;
        poll_clr = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (poll_set)      poll_pending_d = 1'b1;
    else if (poll_clr) poll_pending_d = 1'b0;
    else               poll_pending_d = poll_pending_q;

    err_alarm_d = (alarm_clear ? 4'b0000 : err_alarm_q) | alarm_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                 <= IDLE;
      mm_write_en_q           <= 1'b0;
      mm_read_en_q            <= 1'b0;
      mm_addr_q               <= '0;
      mm_wdata_q              <= '0;
      rsp_valid_q             <= 1'b0;
      rsp_rdata_q             <= '0;
      status_valid_q          <= 1'b0;
      status_active_channel_q <= '0;
      status_signal_present_q <= '0;
      status_err_count_q      <= '0;
      err_alarm_q             <= '0;
      p1_word_q               <= '0;
      prev_cnt_q              <= '0;
      prev_valid_q            <= 1'b0;
      timer_q                 <= '0;
      poll_pending_q          <= 1'b0;
    end else begin
      state_q                 <= state_d;
      mm_write_en_q           <= mm_write_en_d;
      mm_read_en_q            <= mm_read_en_d;
      mm_addr_q               <= mm_addr_d;
      mm_wdata_q              <= mm_wdata_d;
      rsp_valid_q             <= rsp_valid_d;
      rsp_rdata_q             <= rsp_rdata_d;
      status_valid_q          <= status_valid_d;
      status_active_channel_q <= status_active_channel_d;
      status_signal_present_q <= status_signal_present_d;
      status_err_count_q      <= status_err_count_d;
      err_alarm_q             <= err_alarm_d;
      p1_word_q               <= p1_word_d;
      prev_cnt_q              <= prev_cnt_d;
      prev_valid_q            <= prev_valid_d;
      timer_q                 <= timer_d;
      poll_pending_q          <= poll_pending_d;
    end
  end

  assign mm_write_en           = mm_write_en_q;
  assign mm_read_en            = mm_read_en_q;
  assign mm_addr               = mm_addr_q;
  assign mm_wdata              = mm_wdata_q;
  assign rsp_valid             = rsp_valid_q;
  assign rsp_rdata             = rsp_rdata_q;
  assign status_valid          = status_valid_q;
  assign status_active_channel = status_active_channel_q;
  assign status_signal_present = status_signal_present_q;
  assign status_err_count      = status_err_count_q;
  assign err_alarm             = err_alarm_q;

endmodule

// File: tb/tb_mm_host_master.sv
// Directed bench for mm_host_master: host writes/reads, periodic status polling,
// error-burst alarms, poll-vs-command priority and reset mid-read.
module tb_mm_host_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mm_write_en, mm_read_en;
  logic [7:0]  mm_addr;
  logic [31:0] mm_wdata;
  logic [31:0] mm_rdata;
  logic        poll_enable;
  logic        status_valid;
  logic [1:0]  status_active_channel;
  logic [3:0]  status_signal_present;
  logic [31:0] status_err_count;
  logic [3:0]  err_alarm;
  logic        alarm_clear;

  logic [31:0] mem [256];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int e0;

  mm_host_master #(.POLL_PERIOD(20), .ERR_THRESH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mm_write_en(mm_write_en), .mm_read_en(mm_read_en),
    .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_rdata(mm_rdata),
    .poll_enable(poll_enable), .status_valid(status_valid),
    .status_active_channel(status_active_channel),
    .status_signal_present(status_signal_present),
    .status_err_count(status_err_count),
    .err_alarm(err_alarm), .alarm_clear(alarm_clear)
  );

  always #5 clk = ~clk;

  // Registered slave: read data appears the cycle after mm_read_en.
  always @(posedge clk) begin
    if (mm_read_en)  mm_rdata <= mem[mm_addr];
    if (mm_write_en) mem[mm_addr] <= mm_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1] = 32'h0000_002D;
    mem[2] = 32'h0403_0201;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    poll_enable = 1'b0; alarm_clear = 1'b0;

    step(); step();
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_wr_en", 32'(mm_write_en), 0);
    chk("rst_rd_en", 32'(mm_read_en), 0);
    chk("rst_addr", 32'(mm_addr), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_status_valid", 32'(status_valid), 0);
    chk("rst_err_count", status_err_count, 0);
    chk("rst_alarm", 32'(err_alarm), 0);
    rst = 1'b0;
    step();
    chk("idle_ready", 32'(cmd_ready), 1);

    // Host write
    issue(1'b1, 8'h00, 32'hA5A5_0123);
    step();
    cmd_valid = 1'b0;
    chk("wr_strobe", 32'(mm_write_en), 1);
    chk("wr_addr", 32'(mm_addr), 32'h00);
    chk("wr_data", mm_wdata, 32'hA5A5_0123);
    chk("wr_rsp_early", 32'(rsp_valid), 0);
    chk("wr_busy", 32'(cmd_ready), 0);
    step();
    chk("wr_strobe_off", 32'(mm_write_en), 0);
    chk("wr_rsp_valid", 32'(rsp_valid), 1);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_ready_again", 32'(cmd_ready), 1);
    step();
    chk("wr_rsp_pulse", 32'(rsp_valid), 0);

    // Host read of 0x02
    issue(1'b0, 8'h02, 32'h0);
    step();
    cmd_valid = 1'b0;
    chk("rd_strobe", 32'(mm_read_en), 1);
    chk("rd_addr", 32'(mm_addr), 32'h02);
    chk("rd_no_write", 32'(mm_write_en), 0);
    chk("rd_wdata_hold", mm_wdata, 32'hA5A5_0123);
    step();
    chk("rd_strobe_off", 32'(mm_read_en), 0);
    chk("rd_rsp_early", 32'(rsp_valid), 0);
    step();
    chk("rd_rsp_valid", 32'(rsp_valid), 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h0403_0201);
    chk("rd_not_ready", 32'(cmd_ready), 0);
    step();
    chk("rd_ready_again", 32'(cmd_ready), 1);
    chk("rd_rsp_pulse", 32'(rsp_valid), 0);

    // Reset asserted while the read is in RD_WAIT
    issue(1'b0, 8'h01, 32'h0);
    step();
    cmd_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("arst_addr", 32'(mm_addr), 0);
    chk("arst_wdata", mm_wdata, 0);
    chk("arst_rdata", rsp_rdata, 0);
    chk("arst_ready", 32'(cmd_ready), 0);
    step();
    chk("arst_no_rsp", 32'(rsp_valid), 0);
    rst = 1'b0;
    step();
    chk("arst_no_rsp2", 32'(rsp_valid), 0);
    chk("arst_ready_again", 32'(cmd_ready), 1);
    issue(1'b0, 8'h01, 32'h0);
    step();
    cmd_valid = 1'b0;
    chk("post_rst_rd_strobe", 32'(mm_read_en), 1);
    step(); step();
    chk("post_rst_rsp_valid", 32'(rsp_valid), 1);
    chk("post_rst_rsp_rdata", rsp_rdata, 32'h0000_002D);
    step();

    // Periodic polling, POLL_PERIOD = 20
    mem[2] = 32'h0000_00FA;
    poll_enable = 1'b1;
    e0 = cyc;
    run_to(e0 + 20);
    chk("poll_pending_blocks", 32'(cmd_ready), 0);
    step();
    chk("poll1_rd_strobe", 32'(mm_read_en), 1);
    chk("poll1_addr", 32'(mm_addr), 32'h01);
    run_to(e0 + 23);
    chk("poll2_addr", 32'(mm_addr), 32'h02);
    run_to(e0 + 24);
    chk("p1_sv_early", 32'(status_valid), 0);
    step();
    chk("p1_sv", 32'(status_valid), 1);
    chk("p1_active_ch", 32'(status_active_channel), 1);
    chk("p1_sig_present", 32'(status_signal_present), 32'hB);
    chk("p1_err_count", status_err_count, 32'h0000_00FA);
    chk("p1_alarm", 32'(err_alarm), 0);
    step();
    chk("p1_sv_pulse", 32'(status_valid), 0);

    mem[2] = 32'h0003_00FA;
    run_to(e0 + 44);
    chk("p2_sv_early", 32'(status_valid), 0);
    step();
    chk("p2_sv", 32'(status_valid), 1);
    chk("p2_err_count", status_err_count, 32'h0003_00FA);
    chk("p2_alarm", 32'(err_alarm), 0);

    mem[2] = 32'h000B_00FA;
    run_to(e0 + 65);
    chk("p3_sv", 32'(status_valid), 1);
    chk("p3_alarm_ch2", 32'(err_alarm), 32'h4);

    // ch1 rises by 7 (below threshold), ch0 wraps FA->04 (delta 10); clear coincides with set
    mem[2] = 32'h000B_0704;
    run_to(e0 + 84);
    alarm_clear = 1'b1;
    step();
    alarm_clear = 1'b0;
    chk("p4_sv", 32'(status_valid), 1);
    chk("p4_alarm_wrap_setwins", 32'(err_alarm), 32'h1);
    step();
    alarm_clear = 1'b1;
    step();
    alarm_clear = 1'b0;
    chk("alarm_clear", 32'(err_alarm), 0);

    // Host read raised in the cycle the poll becomes pending
    run_to(e0 + 100);
    issue(1'b0, 8'h00, 32'h0);
    chk("conf_ready_low", 32'(cmd_ready), 0);
    run_to(e0 + 103);
    chk("conf_ready_low2", 32'(cmd_ready), 0);
    chk("conf_poll_addr", 32'(mm_addr), 32'h02);
    run_to(e0 + 105);
    chk("conf_sv", 32'(status_valid), 1);
    chk("conf_no_rsp", 32'(rsp_valid), 0);
    chk("conf_alarm", 32'(err_alarm), 0);
    step();
    chk("conf_ready_high", 32'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    chk("conf_rd_strobe", 32'(mm_read_en), 1);
    chk("conf_rd_addr", 32'(mm_addr), 32'h00);
    run_to(e0 + 109);
    chk("conf_rsp_valid", 32'(rsp_valid), 1);
    chk("conf_rsp_rdata", rsp_rdata, 32'hA5A5_0123);

    poll_enable = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
